// File: rtl/parking_counter.sv
// Parking-lot occupancy counter: synchronized, debounced entry/exit sensors
// drive a saturating slot count, full/empty flags, reject pulse and barrier timer.

module parking_counter_filter #(
  parameter int DEBOUNCE = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic ev
);

  localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

  logic          sync1_r;
  logic          sync2_r;
  logic          filt_r;
  logic          filt_d_r;
  logic          ev_r;
  logic [CW-1:0] cnt_r;

  // Synchronizer, debounce filter and rising-edge event register
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r  <= 1'b0;
      sync2_r  <= 1'b0;
      filt_r   <= 1'b0;
      filt_d_r <= 1'b0;
      ev_r     <= 1'b0;
      cnt_r    <= '0;
    end else begin
      sync1_r  <= raw;
      sync2_r  <= sync1_r;
      filt_d_r <= filt_r;
      ev_r     <= filt_r & ~filt_d_r;
      // cnt_r tracks how long the synchronized level has disagreed with filt_r
      if (sync2_r != filt_r) begin
        if (cnt_r == CNT_LAST) begin
          filt_r <= sync2_r;
          cnt_r  <= '0;
        end else begin
          cnt_r  <= cnt_r + CW'(1);
        end
      end else begin
        cnt_r <= '0;
      end
    end
  end

  assign ev = ev_r;

endmodule

module parking_counter #(
  parameter int CAPACITY  = 12,
  parameter int DEBOUNCE  = 4,
  parameter int GATE_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       entry_sensor,
  input  logic       exit_sensor,
  output logic [3:0] count,
  output logic       full,
  output logic       empty,
  output logic       gate_open,
  output logic       reject
);

  localparam logic [3:0] CAP = 4'(CAPACITY);
  localparam int HW = (GATE_HOLD > 1) ? $clog2(GATE_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LOAD = HW'(GATE_HOLD - 1);

  typedef enum logic {
    IDLE = 1'b0,
    OPEN = 1'b1
  } gate_state_t;

  logic          entry_ev_s;
  logic          exit_ev_s;
  logic [3:0]    count_r;
  logic [3:0]    count_next_s;
  logic          full_r;
  logic          empty_r;
  logic          reject_r;
  logic          reject_next_s;
  logic          accept_s;
  gate_state_t   state_r;
  gate_state_t   state_next_s;
  logic [HW-1:0] hold_r;
  logic [HW-1:0] hold_next_s;

  parking_counter_filter #(.DEBOUNCE(DEBOUNCE)) u_entry_filter (
    .clk (clk),
    .rst (rst),
    .raw (entry_sensor),
    .ev  (entry_ev_s)
  );

  parking_counter_filter #(.DEBOUNCE(DEBOUNCE)) u_exit_filter (
    .clk (clk),
    .rst (rst),
    .raw (exit_sensor),
    .ev  (exit_ev_s)
  );

  // Occupancy update and accept/refuse decision for the current events
  always_comb begin
    count_next_s  = count_r;
    accept_s      = 1'b0;
    reject_next_s = 1'b0;
    case ({entry_ev_s, exit_ev_s})
      2'b10: begin
        if (count_r < CAP) begin
          count_next_s = count_r + 4'd1;
          accept_s     = 1'b1;
        end else begin
          reject_next_s = 1'b1;
        end
      end
      2'b01: begin
        if (count_r != 4'd0) begin
          count_next_s = count_r - 4'd1;
          accept_s     = 1'b1;
        end else begin
          accept_s = 1'b0;
        end
      end
      // A simultaneous entry and exit swaps one vehicle for another
      2'b11: accept_s = 1'b1;
      default: accept_s = 1'b0;
    endcase
  end

  // Gate state machine next-state and hold-timer logic
  always_comb begin
    state_next_s = state_r;
    hold_next_s  = hold_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_next_s = OPEN;
          hold_next_s  = HOLD_LOAD;
        end else begin
          state_next_s = IDLE;
        end
      end
      OPEN: begin
        if (accept_s) begin
          hold_next_s = HOLD_LOAD;
        end else if (hold_r == '0) begin
          state_next_s = IDLE;
        end else begin
          hold_next_s = hold_r - HW'(1);
        end
      end
      default: begin
        state_next_s = IDLE;
        hold_next_s  = '0;
      end
    endcase
  end

  // Output and state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r  <= 4'd0;
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
      reject_r <= 1'b0;
      state_r  <= IDLE;
      hold_r   <= '0;
    end else begin
      count_r  <= count_next_s;
      full_r   <= (count_next_s == CAP);
      empty_r  <= (count_next_s == 4'd0);
      reject_r <= reject_next_s;
      state_r  <= state_next_s;
      hold_r   <= hold_next_s;
    end
  end

  assign count     = count_r;
  assign full      = full_r;
  assign empty     = empty_r;
  assign reject    = reject_r;
  assign gate_open = (state_r == OPEN);

endmodule
